// File: rtl/mesi_snoop_responder.sv
// Snoop-side MESI responder for one cache of a two-core system: tag/state/data
// array, foreign-command snooping and a valid/ready writeback port for dirty lines.
module mesi_snoop_responder #(
  parameter int MY_ID   = 0,
  parameter int INDEX_W = 2,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bus_cmd,
  input  logic [7:0]        bus_addr,
  input  logic              bus_grant_id,
  output logic              snoop_busy,
  output logic              snoop_hit,
  output logic              snoop_drop,
  output logic              snoop_err,
  output logic              flush_valid,
  input  logic              flush_ready,
  output logic [7:0]        flush_addr,
  output logic [DATA_W-1:0] flush_data,
  input  logic              loc_we,
  input  logic [7:0]        loc_addr,
  input  logic [1:0]        loc_state,
  input  logic [DATA_W-1:0] loc_data,
  output logic [1:0]        loc_rd_state,
  output logic [DATA_W-1:0] loc_rd_data
);

  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam int TAG_W     = 8 - INDEX_W;
  localparam logic MY_ID_BIT = 1'(MY_ID);

  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_BUSRD  = 2'b01;
  localparam logic [1:0] CMD_BUSRDX = 2'b10;
  localparam logic [1:0] CMD_UPGR   = 2'b11;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} fsm_e;

  fsm_e fsm_q, fsm_d;

  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [1:0]        state_q [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];

  logic              hit_q, hit_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;
  logic [7:0]        faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;

  logic [INDEX_W-1:0] snp_idx_s;
  logic [TAG_W-1:0]   snp_tag_s;
  logic [1:0]         snp_pre_s;
  logic               foreign_s;
  logic               snp_hit_s;
  logic               flush_start_s;
  logic [1:0]         snp_new_state_s;
  logic [INDEX_W-1:0] loc_idx_s;
  logic [TAG_W-1:0]   loc_tag_s;

  assign snp_idx_s = bus_addr[INDEX_W-1:0];
  assign snp_tag_s = bus_addr[7:INDEX_W];
  assign loc_idx_s = loc_addr[INDEX_W-1:0];
  assign loc_tag_s = loc_addr[7:INDEX_W];

  // Snoop decode, FSM next state and next values of the registered pulses.
  always_comb begin
    fsm_d           = fsm_q;
    hit_d           = 1'b0;
    drop_d          = 1'b0;
    err_d           = 1'b0;
    faddr_d         = faddr_q;
    fdata_d         = fdata_q;
    snp_new_state_s = ST_I;
    flush_start_s   = 1'b0;
    snp_pre_s       = state_q[snp_idx_s];
    foreign_s       = (bus_cmd != CMD_NOP) && (bus_grant_id != MY_ID_BIT);
    snp_hit_s       = foreign_s && (fsm_q == IDLE) &&
                      (tag_q[snp_idx_s] == snp_tag_s) && (snp_pre_s != ST_I);

    case (bus_cmd)
      CMD_BUSRD: begin
        snp_new_state_s = ST_S;
        flush_start_s   = (snp_pre_s == ST_M);
      end
      CMD_BUSRDX: begin
        snp_new_state_s = ST_I;
        flush_start_s   = (snp_pre_s == ST_M);
      end
      CMD_UPGR: begin
        snp_new_state_s = ST_I;
        flush_start_s   = 1'b0;
      end
      default: begin
        snp_new_state_s = ST_I;
        flush_start_s   = 1'b0;
      end
    endcase

    case (fsm_q)
      IDLE: begin
        if (snp_hit_s) begin
          hit_d = 1'b1;
          err_d = (bus_cmd == CMD_UPGR) && ((snp_pre_s == ST_E) || (snp_pre_s == ST_M));
          if (flush_start_s) begin
            fsm_d   = FLUSH;
            faddr_d = bus_addr;
            fdata_d = data_q[snp_idx_s];
          end else begin
            fsm_d = IDLE;
          end
        end else begin
          fsm_d = IDLE;
        end
      end
      FLUSH: begin
        drop_d = foreign_s;
        if (flush_ready) begin
          fsm_d = IDLE;
        end else begin
          fsm_d = FLUSH;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  // FSM, pulse and writeback-capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      hit_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      faddr_q <= 8'h00;
      fdata_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      hit_q   <= hit_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  // Line array: the local write lands first, a same-edge snoop then overrides the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]   <= '0;
        state_q[i] <= ST_I;
        data_q[i]  <= '0;
      end
    end else begin
      if (loc_we) begin
        tag_q[loc_idx_s]   <= loc_tag_s;
        state_q[loc_idx_s] <= loc_state;
        data_q[loc_idx_s]  <= loc_data;
      end
      if (snp_hit_s) begin
        state_q[snp_idx_s] <= snp_new_state_s;
      end
    end
  end

  // Local lookup port.
  always_comb begin
    loc_rd_data = data_q[loc_idx_s];
    if ((tag_q[loc_idx_s] == loc_tag_s) && (state_q[loc_idx_s] != ST_I)) begin
      loc_rd_state = state_q[loc_idx_s];
    end else begin
      loc_rd_state = ST_I;
    end
  end

  assign snoop_busy  = (fsm_q == FLUSH);
  assign flush_valid = (fsm_q == FLUSH);
  assign snoop_hit   = hit_q;
  assign snoop_drop  = drop_q;
  assign snoop_err   = err_q;
  assign flush_addr  = faddr_q;
  assign flush_data  = fdata_q;

endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Directed bench for mesi_snoop_responder: a line-level MESI model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mesi_snoop_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] bus_cmd;
  logic [7:0] bus_addr;
  logic       bus_grant_id;
  logic       snoop_busy, snoop_hit, snoop_drop, snoop_err;
  logic       flush_valid, flush_ready;
  logic [7:0] flush_addr, flush_data;
  logic       loc_we;
  logic [7:0] loc_addr;
  logic [1:0] loc_state;
  logic [7:0] loc_data;
  logic [1:0] loc_rd_state;
  logic [7:0] loc_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  mesi_snoop_responder #(.MY_ID(0), .INDEX_W(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_grant_id(bus_grant_id),
    .snoop_busy(snoop_busy), .snoop_hit(snoop_hit), .snoop_drop(snoop_drop),
    .snoop_err(snoop_err), .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_addr(flush_addr), .flush_data(flush_data),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_state(loc_state), .loc_data(loc_data),
    .loc_rd_state(loc_rd_state), .loc_rd_data(loc_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: whole cache lines indexed by addr%4, tag addr/4; MESI as I=0 S=1 E=2 M=3.
  int   m_tag [4];
  int   m_state [4];
  int   m_data [4];
  bit   m_busy, m_hit, m_drop, m_err;
  int   m_faddr, m_fdata;
  bit   chk_en = 1'b0;

  task automatic model_step();
    int  i, t, pre, newst;
    bit  accept, foreign;
    accept = 1'b0;
    newst  = 0;
    i      = bus_addr % 4;
    t      = bus_addr / 4;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_tag[k] = 0; m_state[k] = 0; m_data[k] = 0;
      end
      m_busy = 0; m_hit = 0; m_drop = 0; m_err = 0; m_faddr = 0; m_fdata = 0;
      chk_en = 1'b1;
      return;
    end
    m_hit = 0; m_drop = 0; m_err = 0;
    foreign = (bus_cmd != 2'd0) && (bus_grant_id != 1'b0);
    if (m_busy) begin
      if (foreign) m_drop = 1;
      if (flush_ready) m_busy = 0;
    end else if (foreign && m_tag[i] == t && m_state[i] != 0) begin
      pre    = m_state[i];
      accept = 1'b1;
      m_hit  = 1;
      newst  = (bus_cmd == 2'd1) ? 1 : 0;
      if (bus_cmd == 2'd3 && pre >= 2) m_err = 1;
      if (bus_cmd != 2'd3 && pre == 3) begin
        m_busy = 1; m_faddr = bus_addr; m_fdata = m_data[i];
      end
    end
    if (loc_we) begin
      m_tag[loc_addr % 4]   = loc_addr / 4;
      m_state[loc_addr % 4] = loc_state;
      m_data[loc_addr % 4]  = loc_data;
    end
    if (accept) m_state[i] = newst;
  endtask

  always @(posedge clk) model_step();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int li, exp_st;
    if (chk_en) begin
      li = loc_addr % 4;
      exp_st = (m_tag[li] == loc_addr / 4 && m_state[li] != 0) ? m_state[li] : 0;
      check("m_hit",   32'(snoop_hit),   32'(m_hit));
      check("m_drop",  32'(snoop_drop),  32'(m_drop));
      check("m_err",   32'(snoop_err),   32'(m_err));
      check("m_busy",  32'(snoop_busy),  32'(m_busy));
      check("m_valid", 32'(flush_valid), 32'(m_busy));
      if (m_busy) begin
        check("m_faddr", 32'(flush_addr), 32'(m_faddr));
        check("m_fdata", 32'(flush_data), 32'(m_fdata));
      end
      check("m_rd_state", 32'(loc_rd_state), 32'(exp_st));
      check("m_rd_data",  32'(loc_rd_data),  32'(m_data[li]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic loc_write(input logic [7:0] a, input logic [1:0] st, input logic [7:0] d);
    loc_we = 1'b1; loc_addr = a; loc_state = st; loc_data = d;
    cyc();
    loc_we = 1'b0;
  endtask

  task automatic snoop(input logic [1:0] cmd, input logic [7:0] a, input logic gid);
    bus_cmd = cmd; bus_addr = a; bus_grant_id = gid;
    cyc();
    bus_cmd = 2'b00;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [1:0] exp);
    loc_addr = a;
    #1;
    check(name, 32'(loc_rd_state), 32'(exp));
  endtask

  int cnt;

  initial begin
    rst = 1'b1; bus_cmd = 2'b00; bus_addr = 8'h00; bus_grant_id = 1'b0;
    flush_ready = 1'b0; loc_we = 1'b0; loc_addr = 8'h00; loc_state = 2'b00; loc_data = 8'h00;
    cyc(); cyc();
    check("rst_valid", 32'(flush_valid), 32'd0);
    check("rst_busy",  32'(snoop_busy),  32'd0);
    check("rst_faddr", 32'(flush_addr),  32'd0);
    check("rst_fdata", 32'(flush_data),  32'd0);
    check("rst_hit",   32'(snoop_hit),   32'd0);
    rd_check("rst_rd", 8'h15, 2'b00);
    rst = 1'b0;

    // E line downgraded to S by a foreign BusRd, no writeback
    loc_write(8'h15, 2'b10, 8'h11);
    snoop(2'b01, 8'h15, 1'b1);
    check("rd_e_hit",   32'(snoop_hit),   32'd1);
    check("rd_e_valid", 32'(flush_valid), 32'd0);
    rd_check("rd_e_state", 8'h15, 2'b01);
    cyc();
    check("rd_e_hit_gone", 32'(snoop_hit), 32'd0);

    // own-ID command is not snooped
    loc_write(8'h22, 2'b11, 8'hA5);
    snoop(2'b01, 8'h22, 1'b0);
    check("own_hit",   32'(snoop_hit),   32'd0);
    check("own_valid", 32'(flush_valid), 32'd0);
    rd_check("own_state", 8'h22, 2'b11);

    // BusRdX on M: writeback held 3 cycles, drop of a foreign BusRd while busy
    loc_write(8'h30, 2'b10, 8'h33);
    snoop(2'b10, 8'h22, 1'b1);
    cnt = 0;
    for (int k = 0; k < 7; k++) begin
      if (flush_valid && snoop_busy && flush_addr == 8'h22 && flush_data == 8'hA5) cnt++;
      if (k == 2) check("drop_pulse", 32'(snoop_drop), 32'd1);
      if (k == 1) begin
        bus_cmd = 2'b01; bus_addr = 8'h30; bus_grant_id = 1'b1;
      end else begin
        bus_cmd = 2'b00;
      end
      flush_ready = (k == 3);
      cyc();
    end
    flush_ready = 1'b0;
    check("flush_span", 32'(cnt), 32'd4);
    check("flush_done", 32'(flush_valid), 32'd0);
    rd_check("rdx_m_state", 8'h22, 2'b00);
    rd_check("dropped_unchanged", 8'h30, 2'b10);

    // ready without valid does nothing
    flush_ready = 1'b1;
    cyc();
    check("ready_idle", 32'(flush_valid), 32'd0);
    flush_ready = 1'b0;

    // BusUpgr cases
    loc_write(8'h0C, 2'b01, 8'h44);
    loc_write(8'h0D, 2'b11, 8'h55);
    snoop(2'b11, 8'h4C, 1'b1);
    check("upg_miss_hit", 32'(snoop_hit), 32'd0);
    rd_check("upg_miss_state", 8'h0C, 2'b01);
    snoop(2'b11, 8'h0C, 1'b1);
    check("upg_s_hit", 32'(snoop_hit), 32'd1);
    check("upg_s_err", 32'(snoop_err), 32'd0);
    rd_check("upg_s_state", 8'h0C, 2'b00);
    snoop(2'b11, 8'h0D, 1'b1);
    check("upg_m_hit",   32'(snoop_hit),   32'd1);
    check("upg_m_err",   32'(snoop_err),   32'd1);
    check("upg_m_valid", 32'(flush_valid), 32'd0);
    rd_check("upg_m_state", 8'h0D, 2'b00);

    // same-edge local write and snoop on one index: snoop wins the state field
    loc_write(8'h0D, 2'b10, 8'h66);
    loc_we = 1'b1; loc_addr = 8'h0D; loc_state = 2'b11; loc_data = 8'h77;
    bus_cmd = 2'b01; bus_addr = 8'h0D; bus_grant_id = 1'b1;
    cyc();
    loc_we = 1'b0; bus_cmd = 2'b00;
    check("same_hit",   32'(snoop_hit),   32'd1);
    check("same_valid", 32'(flush_valid), 32'd0);
    rd_check("same_state", 8'h0D, 2'b01);
    check("same_data", 32'(loc_rd_data), 32'h77);

    // reset in the middle of a writeback
    loc_write(8'h22, 2'b11, 8'hA5);
    snoop(2'b01, 8'h22, 1'b1);
    check("pre_rst_valid", 32'(flush_valid), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_flush_valid", 32'(flush_valid), 32'd0);
    check("rst_flush_busy",  32'(snoop_busy),  32'd0);
    rd_check("rst_l0", 8'h0C, 2'b00);
    rd_check("rst_l1", 8'h15, 2'b00);
    rd_check("rst_l2", 8'h22, 2'b00);
    rd_check("rst_l3", 8'h03, 2'b00);
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mesi_snoop_responder.md
# mesi_snoop_responder

Snoop-side responder for one cache in the two-core MESI system. It observes the single command/address stream driven by the bus arbiter and ignores transactions issued by its own core. On a tag hit it updates that line's MESI state and reports sharing. When a snooped line is Modified, it writes the dirty data back through a valid/ready flush port. It also holds the per-line tag/state/data array that the local cache controller installs into and queries.

## Interface
Parameters:
- MY_ID, 0: core ID of this cache; bus transactions granted to MY_ID are not snooped.
- INDEX_W, 2: index bits; NUM_LINES = 2**INDEX_W, direct-mapped.
- DATA_W, 8: data bits per line.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- bus_cmd  in  2  bus_request from arbiter: No_OP=00, BusRd=01, BusRdX=10, BusUpgr=11.
- bus_addr  in  8  snooped address; index = addr[INDEX_W-1:0], tag = addr[7:INDEX_W].
- bus_grant_id  in  1  core owning the current bus command.
- snoop_busy  out  1  high while in FLUSH; bus commands are not accepted.
- snoop_hit  out  1  one-cycle pulse: previous-cycle snoop hit a non-I line.
- snoop_drop  out  1  one-cycle pulse: a foreign command arrived while busy and was discarded.
- snoop_err  out  1  one-cycle pulse: BusUpgr hit a line in M or E.
- flush_valid  out  1  writeback request valid.
- flush_ready  in  1  writeback accepted.
- flush_addr  out  8  {tag, index} of the flushed line.
- flush_data  out  DATA_W  dirty data.
- loc_we  in  1  local install/update.
- loc_addr  in  8  local address, for write and lookup.
- loc_state  in  2  MESI state to write: I=00, S=01, E=10, M=11.
- loc_data  in  DATA_W  data to write.
- loc_rd_state  out  2  combinational: state[idx] if the tag matches and the state is not I, else I.
- loc_rd_data  out  DATA_W  combinational: data[idx].

## Operation
- FSM states: IDLE and FLUSH.
- A snoop is accepted in IDLE when bus_cmd != No_OP and bus_grant_id != MY_ID. Lookup is combinational and the array update is written at the end of that cycle.
- Hit condition: tag[idx] == addr tag and state[idx] != I. On a miss there is no state change and no pulse.
- BusRd hit:
  - M: state becomes S; flush is started.
  - E: state becomes S.
  - S: state stays S.
- BusRdX hit:
  - M: state becomes I; flush is started.
  - E or S: state becomes I.
- BusUpgr hit:
  - S: state becomes I.
  - E or M: state becomes I; snoop_err pulses; no flush.
- Flush start: flush_addr and flush_data are captured from the pre-update line. The FSM moves IDLE to FLUSH.
- FLUSH: flush_valid and snoop_busy are held high with stable addr/data until flush_valid and flush_ready are both high at an edge, then the FSM returns to IDLE.
- A foreign command arriving in FLUSH is ignored and pulses snoop_drop. Own-ID commands never cause a drop.
- Local write with loc_we: tag, state and data are written at loc_addr.
- Same-edge loc_we and snoop update to the same index: the local write is applied first and the snoop state update overrides the state field. Tag and data come from the local write.
- Data is never modified by a snoop.

## Timing
- Reset values:
  - all states I, tags 0, data 0;
  - FSM in IDLE;
  - snoop_busy, snoop_hit, snoop_drop, snoop_err, flush_valid = 0;
  - flush_addr and flush_data = 0.
- Snoop accepted in cycle N: the array is updated at edge N→N+1. snoop_hit and snoop_err are high during N+1 only.
- Flush: flush_valid is high from N+1. The earliest completion is edge N+1→N+2 if flush_ready=1. snoop_busy is low and new snoops are accepted from N+2.
- flush_ready while flush_valid=0 has no effect.
- snoop_drop is high in the cycle after the dropped command.
- Reset asserted mid-FLUSH aborts the writeback. The block is in reset state the cycle after rst is sampled high; rst has priority over all events.
- loc_rd_state and loc_rd_data reflect array contents as of the last edge.

## Test plan
- Install addr 0x15 as E via the local port, then foreign BusRd 0x15 → snoop_hit pulse at N+1, loc_rd_state=S, no flush_valid.
- Install 0x22 as M with data 0xA5, foreign BusRdX 0x22, flush_ready held low 3 cycles then high:
  - flush_valid=1 with addr 0x22 and data 0xA5 stable for 4 cycles;
  - snoop_busy high for the same span;
  - line ends in I.
- Own-ID BusRd 0x22 with the line in M → no state change, no pulse.
- During FLUSH, foreign BusRd 0x30 → snoop_drop pulse; state of 0x30 unchanged after the flush completes.
- BusUpgr hits: 0x0C in S → I with no err; 0x0D in M → I with a snoop_err pulse and no flush. Tag mismatch 0x4C vs installed 0x0C → no change.
- rst asserted during FLUSH → next cycle flush_valid=0, snoop_busy=0, every loc_rd_state=I.
